wb_arb2: RTL and testbench
==========================

# wb_arb2

Two-master, one-slave Wishbone arbiter with round-robin fairness and a bus-timeout watchdog. It lets the LM32 instruction and data ports share a single downstream slave segment, for example one DDR port, so that neither port can starve the other and a missing slave never hangs the CPU. It sits between the CPU master ports and the interconnect or slave, and adds a one-cycle grant latency.

## Interface
Parameters:
- `timeout_cycles`, default 255: wait cycles before the arbiter terminates a pending access with an error. 0 disables the watchdog. Legal range 0..65535.

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `m0_adr_i` / `m1_adr_i`  in  32  master address.
- `m0_dat_i` / `m1_dat_i`  in  32  master write data.
- `m0_sel_i` / `m1_sel_i`  in  4  byte selects.
- `m0_we_i`, `m0_cyc_i`, `m0_stb_i` / `m1_…`  in  1  write enable, cycle, strobe.
- `m0_dat_o` / `m1_dat_o`  out  32  read data; both equal `s_dat_i`.
- `m0_ack_o`, `m0_err_o`, `m0_rty_o` / `m1_…`  out  1  termination signals, routed to the granted master only.
- `s_adr_o`  out  32, `s_dat_o`  out  32, `s_sel_o`  out  4, `s_we_o`  out  1, `s_cyc_o`  out  1, `s_stb_o`  out  1: slave-side request.
- `s_dat_i`  in  32, `s_ack_i`  in  1, `s_err_i`  in  1, `s_rty_i`  in  1: slave-side response.
- `grant_o`  out  2  one-hot current grant; 00 when idle.
- `timeout_o`  out  1  one-cycle pulse when the watchdog fires, intended for LAC probing.

## Operation
- State machine: IDLE, GNT0, GNT1. A registered `last` bit records the master served most recently; its reset value is 1, so m0 wins the first tie.
- IDLE:
  - Only `m0_cyc_i` high → GNT0.
  - Only `m1_cyc_i` high → GNT1.
  - Both high → grant the master that is not `last`.
  - Neither high → stay in IDLE.
- GNTx: hold the grant for as long as `mx_cyc_i` stays high. This covers multi-strobe bursts and locked sequences, with no preemption.
  - `mx_cyc_i` low and the other master's `cyc` high → go directly to GNTother.
  - `mx_cyc_i` low and the other master idle → IDLE.
  - `last` is set to x on leaving GNTx.
- Slave mux is combinational from the granted master:
  - `s_adr_o`, `s_dat_o`, `s_sel_o`, `s_we_o` come from the granted master; in IDLE they come from m0.
  - `s_cyc_o = grant & mx_cyc_i`.
  - `s_stb_o = grant & mx_stb_i`.
  - In IDLE, `s_cyc_o` and `s_stb_o` are 0.
- Responses:
  - `mx_ack_o = gnt_x & s_ack_i`.
  - `mx_rty_o = gnt_x & s_rty_i`.
  - `mx_err_o = gnt_x & (s_err_i | wd_fire)`.
  - The non-granted master sees ack, err and rty all at 0.
- Watchdog:
  - A 16-bit `wcnt` increments every cycle in which `s_stb_o` is high and none of ack/err/rty is high.
  - It clears on any termination, on `s_stb_o` low, and on a grant change.
  - `wd_fire = pending & (wcnt == timeout_cycles-1) & (timeout_cycles != 0)`.
  - On fire: `wcnt` clears and `timeout_o` is high for that cycle.
  - A slave termination in the same cycle has priority: `wd_fire` is suppressed and there is no double termination.
  - `wcnt` saturates and never wraps.
- Reset:
  - From any state, mid-transaction included, the next state is IDLE, `last` is 1 and `wcnt` is 0.
  - The outputs `grant_o`, `s_cyc_o`, `s_stb_o`, all master ack/err/rty and `timeout_o` are 0 while `reset` is high and in the first cycle after it.

## Timing
- Grant latency:
  - `cyc` rises in cycle N → GNT registered at edge N+1 → `s_cyc_o` and `s_stb_o` visible in cycle N+1.
  - A zero-wait slave acks in N+1, so a single access takes 2 cycles from request.
- Handover: the current master drops `cyc` in cycle N → the other master's `s_cyc_o` is visible in N+1. There are no idle cycles between back-to-back grants.
- Termination latency: 0 cycles. Slave ack/err/rty are passed combinationally to the granted master.
- Watchdog: with `timeout_cycles = T`, `s_stb_o` rising in cycle K with no slave response gives err in cycle K+T-1, i.e. the T-th wait cycle.
- Grant changes only at a clock edge and only while the current master's `cyc` is low.

## Test plan
- **m0 read alone:** m0 cyc/stb at cycle 1, addr 0x40000010; slave acks the first cycle it sees stb with data 0xDEADBEEF → `grant_o` = 01 in cycle 2, `m0_ack_o` and `m0_dat_o` = 0xDEADBEEF in cycle 2, `m1_ack_o` stays 0.
- **Simultaneous requests:** both masters request in the same cycle, repeated 4 times, 1-cycle ack each → grants in the order m0, m1, m0, m1, with no idle cycle between handovers.
- **Burst lock:** m1 holds `cyc` across 3 strobes while m0 requests continuously → `grant_o` = 10 throughout; m0 is granted in the cycle after `m1_cyc_i` falls.
- **Watchdog:** `timeout_cycles = 4`, slave never responds, m0 strobes at cycle K → `m0_err_o` and `timeout_o` pulse exactly in cycle K+3.
- **Watchdog/ack collision:** slave acks in that same cycle K+3 → only ack, `timeout_o` stays 0.
- **Watchdog disabled:** `timeout_cycles = 0`, 1000 stalled cycles → no err.
- **Reset mid-transaction:** `reset` asserted during GNT1 with a pending stb → next cycle `grant_o` = 00, `s_cyc_o` = 0; after release, a simultaneous request goes to m0.

Source files
------------

// File: rtl/wb_arb2.sv
// wb_arb2: two-master Wishbone arbiter with round-robin grant and bus-timeout watchdog
module wb_arb2 #(
    parameter int timeout_cycles = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] m0_adr_i,
    input  logic [31:0] m0_dat_i,
    input  logic [3:0]  m0_sel_i,
    input  logic        m0_we_i,
    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    output logic [31:0] m0_dat_o,
    output logic        m0_ack_o,
    output logic        m0_err_o,
    output logic        m0_rty_o,
    input  logic [31:0] m1_adr_i,
    input  logic [31:0] m1_dat_i,
    input  logic [3:0]  m1_sel_i,
    input  logic        m1_we_i,
    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    output logic [31:0] m1_dat_o,
    output logic        m1_ack_o,
    output logic        m1_err_o,
    output logic        m1_rty_o,
    output logic [31:0] s_adr_o,
    output logic [31:0] s_dat_o,
    output logic [3:0]  s_sel_o,
    output logic        s_we_o,
    output logic        s_cyc_o,
    output logic        s_stb_o,
    input  logic [31:0] s_dat_i,
    input  logic        s_ack_i,
    input  logic        s_err_i,
    input  logic        s_rty_i,
    output logic [1:0]  grant_o,
    output logic        timeout_o
);
    typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;
    state_t state;
    logic last;
    logic [15:0] wcnt;
    logic [1:0] g;
    logic chg, pending, wd_fire;
    // grant is masked during reset so a stale state never reaches the bus
    assign g = {state == GNT1, state == GNT0} & {2{!reset}};
    assign grant_o = g;
    assign s_cyc_o = |(g & {m1_cyc_i, m0_cyc_i});
    assign s_stb_o = |(g & {m1_stb_i, m0_stb_i});
    assign s_adr_o = g[1] ? m1_adr_i : m0_adr_i;
    assign s_dat_o = g[1] ? m1_dat_i : m0_dat_i;
    assign s_sel_o = g[1] ? m1_sel_i : m0_sel_i;
    assign s_we_o  = g[1] ? m1_we_i : m0_we_i;
    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;
    assign pending = s_stb_o && !(s_ack_i || s_err_i || s_rty_i);
    assign wd_fire = pending && timeout_cycles != 0 && wcnt == 16'(timeout_cycles - 1);
    assign timeout_o = wd_fire;
    assign m0_ack_o = g[0] & s_ack_i;
    assign m1_ack_o = g[1] & s_ack_i;
    assign m0_rty_o = g[0] & s_rty_i;
    assign m1_rty_o = g[1] & s_rty_i;
    assign m0_err_o = g[0] & (s_err_i | wd_fire);
    assign m1_err_o = g[1] & (s_err_i | wd_fire);
    assign chg = state == GNT0 ? !m0_cyc_i : state == GNT1 ? !m1_cyc_i : (m0_cyc_i || m1_cyc_i);
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            last  <= 1'b1;
            wcnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (m0_cyc_i && (!m1_cyc_i || last)) state <= GNT0;
                    else if (m1_cyc_i) state <= GNT1;
                end
                GNT0: if (!m0_cyc_i) begin
                    last  <= 1'b0;
                    state <= m1_cyc_i ? GNT1 : IDLE;
                end
                GNT1: if (!m1_cyc_i) begin
                    last  <= 1'b1;
                    state <= m0_cyc_i ? GNT0 : IDLE;
                end
                default: state <= IDLE;
            endcase
            wcnt <= (!pending || wd_fire || chg) ? '0 : wcnt == 16'hFFFF ? wcnt : wcnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_wb_arb2.sv
// tb_wb_arb2: table-driven bench for wb_arb2 with a scoreboard queue and watchdog stall run
module tb_wb_arb2;
    localparam logic [31:0] M0A = 32'h4000_0010, M1A = 32'h8000_0020;
    localparam logic [31:0] M0D = 32'h1111_2222, M1D = 32'h3333_4444;
    localparam logic [3:0]  M0S = 4'hF, M1S = 4'h3;
    localparam logic [31:0] SD  = 32'hDEAD_BEEF;
    logic clk = 1'b0, reset = 1'b1;
    logic m0_cyc = 1'b0, m0_stb = 1'b0, m1_cyc = 1'b0, m1_stb = 1'b0;
    logic s_ack = 1'b0, s_err = 1'b0, s_rty = 1'b0;
    logic [31:0] m0_adr = M0A, m1_adr = M1A, m0_wd = M0D, m1_wd = M1D, s_dat = SD;
    logic [3:0] m0_sel = M0S, m1_sel = M1S;
    logic m0_we = 1'b0, m1_we = 1'b1;
    logic [31:0] m0_rd, m1_rd, s_adr, s_wd;
    logic [3:0] s_sel;
    logic s_we, s_cyc, s_stb, m0_ack, m1_ack, m0_err, m1_err, m0_rty, m1_rty, tmo;
    logic [1:0] grant;
    logic [31:0] d_m0_rd, d_m1_rd, d_s_adr, d_s_wd;
    logic [3:0] d_s_sel;
    logic d_s_we, d_s_cyc, d_s_stb, d_m0_ack, d_m1_ack, d_m0_err, d_m1_err, d_m0_rty, d_m1_rty, d_tmo;
    logic [1:0] d_grant;
    always #5 clk = ~clk;
    wb_arb2 #(.timeout_cycles(4)) dut (
        .clk(clk), .reset(reset),
        .m0_adr_i(m0_adr), .m0_dat_i(m0_wd), .m0_sel_i(m0_sel), .m0_we_i(m0_we),
        .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_dat_o(m0_rd),
        .m0_ack_o(m0_ack), .m0_err_o(m0_err), .m0_rty_o(m0_rty),
        .m1_adr_i(m1_adr), .m1_dat_i(m1_wd), .m1_sel_i(m1_sel), .m1_we_i(m1_we),
        .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_dat_o(m1_rd),
        .m1_ack_o(m1_ack), .m1_err_o(m1_err), .m1_rty_o(m1_rty),
        .s_adr_o(s_adr), .s_dat_o(s_wd), .s_sel_o(s_sel), .s_we_o(s_we),
        .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_dat_i(s_dat),
        .s_ack_i(s_ack), .s_err_i(s_err), .s_rty_i(s_rty),
        .grant_o(grant), .timeout_o(tmo)
    );
    wb_arb2 #(.timeout_cycles(0)) dut_d (
        .clk(clk), .reset(reset),
        .m0_adr_i(m0_adr), .m0_dat_i(m0_wd), .m0_sel_i(m0_sel), .m0_we_i(m0_we),
        .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_dat_o(d_m0_rd),
        .m0_ack_o(d_m0_ack), .m0_err_o(d_m0_err), .m0_rty_o(d_m0_rty),
        .m1_adr_i(m1_adr), .m1_dat_i(m1_wd), .m1_sel_i(m1_sel), .m1_we_i(m1_we),
        .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_dat_o(d_m1_rd),
        .m1_ack_o(d_m1_ack), .m1_err_o(d_m1_err), .m1_rty_o(d_m1_rty),
        .s_adr_o(d_s_adr), .s_dat_o(d_s_wd), .s_sel_o(d_s_sel), .s_we_o(d_s_we),
        .s_cyc_o(d_s_cyc), .s_stb_o(d_s_stb), .s_dat_i(s_dat),
        .s_ack_i(s_ack), .s_err_i(s_err), .s_rty_i(s_rty),
        .grant_o(d_grant), .timeout_o(d_tmo)
    );
    // in  = {reset, m0 cyc/stb, m1 cyc/stb, ack, err, rty}
    // ex  = {grant, s_cyc/s_stb, ack0/ack1, err0/err1, rty0/rty1, timeout}
    typedef struct packed {
        logic [7:0]  in;
        logic [10:0] ex;
    } vec_t;
    vec_t tbl[$];
    logic [10:0] sb[$];
    int n_cmp = 0, n_bad = 0;
    task automatic add(input logic [7:0] i, input logic [10:0] e);
        tbl.push_back('{i, e});
    endtask
    task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h", name, got, exp);
        end
    endtask
    initial begin
        logic [10:0] ex;
        int fires, errs, dfires;
        add(8'b1_00_00_000, 11'b00_00_00_00_00_0);
        add(8'b1_00_00_000, 11'b00_00_00_00_00_0);
        // m0 read alone
        add(8'b0_11_00_000, 11'b00_00_00_00_00_0);
        add(8'b0_11_00_100, 11'b01_11_10_00_00_0);
        add(8'b0_00_00_000, 11'b01_00_00_00_00_0);
        add(8'b0_00_00_000, 11'b00_00_00_00_00_0);
        // reset during GNT1 with a pending strobe, then a tie goes to m0
        add(8'b0_00_11_000, 11'b00_00_00_00_00_0);
        add(8'b0_00_11_000, 11'b10_11_00_00_00_0);
        add(8'b1_11_11_000, 11'b00_00_00_00_00_0);
        add(8'b0_11_11_000, 11'b00_00_00_00_00_0);
        // simultaneous requests alternate m0, m1, m0, m1
        add(8'b0_11_11_100, 11'b01_11_10_00_00_0);
        add(8'b0_00_11_000, 11'b01_00_00_00_00_0);
        add(8'b0_11_11_100, 11'b10_11_01_00_00_0);
        add(8'b0_11_00_000, 11'b10_00_00_00_00_0);
        add(8'b0_11_11_100, 11'b01_11_10_00_00_0);
        add(8'b0_00_11_000, 11'b01_00_00_00_00_0);
        add(8'b0_00_11_100, 11'b10_11_01_00_00_0);
        add(8'b0_00_00_000, 11'b10_00_00_00_00_0);
        add(8'b0_00_00_000, 11'b00_00_00_00_00_0);
        // m1 burst with ack, rty, err while m0 waits
        add(8'b0_00_11_000, 11'b00_00_00_00_00_0);
        add(8'b0_11_11_100, 11'b10_11_01_00_00_0);
        add(8'b0_11_10_000, 11'b10_10_00_00_00_0);
        add(8'b0_11_11_001, 11'b10_11_00_00_01_0);
        add(8'b0_11_11_010, 11'b10_11_00_01_00_0);
        add(8'b0_11_00_000, 11'b10_00_00_00_00_0);
        add(8'b0_11_00_100, 11'b01_11_10_00_00_0);
        add(8'b0_00_00_000, 11'b01_00_00_00_00_0);
        add(8'b0_00_00_000, 11'b00_00_00_00_00_0);
        // watchdog fires on the 4th wait cycle, then loses to a same-cycle ack
        add(8'b0_11_00_000, 11'b00_00_00_00_00_0);
        add(8'b0_11_00_000, 11'b01_11_00_00_00_0);
        add(8'b0_11_00_000, 11'b01_11_00_00_00_0);
        add(8'b0_11_00_000, 11'b01_11_00_00_00_0);
        add(8'b0_11_00_000, 11'b01_11_00_10_00_1);
        add(8'b0_11_00_000, 11'b01_11_00_00_00_0);
        add(8'b0_11_00_000, 11'b01_11_00_00_00_0);
        add(8'b0_11_00_000, 11'b01_11_00_00_00_0);
        add(8'b0_11_00_100, 11'b01_11_10_00_00_0);
        add(8'b0_00_00_000, 11'b01_00_00_00_00_0);
        add(8'b0_00_00_000, 11'b00_00_00_00_00_0);
        for (int i = 0; i < tbl.size(); i++) begin
            @(posedge clk);
            #1;
            {reset, m0_cyc, m0_stb, m1_cyc, m1_stb, s_ack, s_err, s_rty} = tbl[i].in;
            sb.push_back(tbl[i].ex);
            @(negedge clk);
            ex = sb.pop_front();
            check($sformatf("vec%0d flags", i),
                  256'({grant, s_cyc, s_stb, m0_ack, m1_ack, m0_err, m1_err, m0_rty, m1_rty, tmo}),
                  256'(ex));
            check($sformatf("vec%0d mux", i),
                  256'({s_adr, s_wd, s_sel, s_we, m0_rd, m1_rd}),
                  256'({ex[10] ? M1A : M0A, ex[10] ? M1D : M0D, ex[10] ? M1S : M0S, ex[10], SD, SD}));
            check($sformatf("vec%0d nowd", i),
                  256'({d_grant, d_m0_err, d_m1_err, d_tmo}),
                  256'({ex[10:9], ex[4] & ~ex[0], ex[3] & ~ex[0], 1'b0}));
        end
        // long stall on m1: timeout 4 fires every 4 cycles, disabled watchdog never fires
        @(posedge clk);
        #1;
        {reset, m0_cyc, m0_stb, m1_cyc, m1_stb, s_ack, s_err, s_rty} = 8'b0_00_11_000;
        fires = 0;
        errs = 0;
        dfires = 0;
        repeat (1001) begin
            @(negedge clk);
            if (tmo) fires++;
            if (m1_err) errs++;
            if (d_m1_err || d_m0_err || d_tmo) dfires++;
        end
        check("stall fires", 256'(fires), 256'(250));
        check("stall m1 errs", 256'(errs), 256'(250));
        check("disabled fires", 256'(dfires), 256'(0));
        m1_cyc = 1'b0;
        m1_stb = 1'b0;
        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
